switch_forwarding_engine: RTL and testbench

SWITCH_FORWARDING_ENGINE -- requirements
Module: switch_forwarding_engine

---
 rtl/switch_pkg.sv | 30 +++
 rtl/mac_learning_table.sv | 114 +++++++++++
 rtl/switch_forwarding_engine.sv | 207 ++++++++++++++++++++
 tb/tb_switch_forwarding_engine.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and constants for the switch forwarding engine.
//   fsm_state_t   : forwarding FSM states
//   mac_entry_t   : one MAC learning table entry (valid, mac, port, age)
//   HEADER_BYTES  : destination + source MAC bytes buffered before lookup
//   BROADCAST_MAC : all-ones destination that always floods
package switch_pkg;

  localparam int          HEADER_BYTES  = 12;
  localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

  // Wide enough for up to 16 ports and an age limit of up to 255 ticks.
  localparam int PORT_W = 4;
  localparam int AGE_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    LOOKUP,
    FORWARD_HEADER,
    FORWARD_PAYLOAD
  } fsm_state_t;

  typedef struct packed {
    logic              valid;
    logic [47:0]       mac;
    logic [PORT_W-1:0] port;
    logic [AGE_W-1:0]  age;
  } mac_entry_t;

endpackage

// File: rtl/mac_learning_table.sv
// MAC learning table: parallel lookup, learning with replacement, optional aging.
// Optional feature macro: SWITCH_FORWARDING_ENGINE_AGING_EN (enables aging).
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   lookup_mac              : destination MAC to search (combinational result)
//   lookup_hit, lookup_port : match found among valid entries, its port
//   learn_en                : pulse to learn learn_mac on learn_port this cycle
//   learn_mac, learn_port   : source address and ingress port to record
module mac_learning_table
  import switch_pkg::*;
#(
  parameter int MAC_TABLE_DEPTH = 8,
  parameter int AGE_TICK_CYCLES = 1000000,
  parameter int AGE_LIMIT       = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [47:0]       lookup_mac,
  output logic              lookup_hit,
  output logic [PORT_W-1:0] lookup_port,
  input  logic              learn_en,
  input  logic [47:0]       learn_mac,
  input  logic [PORT_W-1:0] learn_port
);

  localparam int IDX_W = (MAC_TABLE_DEPTH > 1) ? $clog2(MAC_TABLE_DEPTH) : 1;

  mac_entry_t       table_q [MAC_TABLE_DEPTH];
  logic [IDX_W-1:0] repl_ptr_q;

  logic             learn_match;
  logic             learn_free;
  logic [IDX_W-1:0] match_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] learn_idx;

  // Descending scan: the last assignment is the lowest matching index.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_port = '0;
    for (int i = MAC_TABLE_DEPTH - 1; i >= 0; i--) begin
      if (table_q[i].valid && (table_q[i].mac == lookup_mac)) begin
        lookup_hit  = 1'b1;
        lookup_port = table_q[i].port;
      end
    end
  end

  // Learning target: existing entry, else first free slot, else replacement pointer.
  always_comb begin
    learn_match = 1'b0;
    learn_free  = 1'b0;
    match_idx   = '0;
    free_idx    = '0;
    for (int i = MAC_TABLE_DEPTH - 1; i >= 0; i--) begin
      if (table_q[i].valid && (table_q[i].mac == learn_mac)) begin
        learn_match = 1'b1;
        match_idx   = IDX_W'(i);
      end
      if (!table_q[i].valid) begin
        learn_free = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    if (learn_match)     learn_idx = match_idx;
    else if (learn_free) learn_idx = free_idx;
    else                 learn_idx = repl_ptr_q;
  end

`ifdef SWITCH_FORWARDING_ENGINE_AGING_EN
  logic [31:0] tick_cnt_q;
  logic        age_tick;

  assign age_tick = (tick_cnt_q == 32'(AGE_TICK_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) tick_cnt_q <= '0;
    else          tick_cnt_q <= age_tick ? '0 : tick_cnt_q + 32'd1;
  end
`else
  // Age stays zero in this build; the sinks keep the shared entry layout and
  // the aging parameters from reading as dead configuration.
  localparam int unused_age_cfg = AGE_TICK_CYCLES + AGE_LIMIT;
  logic unused_age;
  always_comb begin
    unused_age = 1'b0;
    for (int i = 0; i < MAC_TABLE_DEPTH; i++) unused_age = unused_age | (|table_q[i].age);
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAC_TABLE_DEPTH; i++) table_q[i] <= '0;
      repl_ptr_q <= '0;
    end else begin
`ifdef SWITCH_FORWARDING_ENGINE_AGING_EN
      if (age_tick) begin
        for (int i = 0; i < MAC_TABLE_DEPTH; i++) begin
          if (table_q[i].valid) begin
            if (table_q[i].age != '1) table_q[i].age <= table_q[i].age + 1'b1;
            if ((int'(table_q[i].age) + 1) >= AGE_LIMIT) table_q[i].valid <= 1'b0;
          end
        end
      end
`endif
      // Placed after aging so a same-cycle learn overrides the aging update.
      if (learn_en) begin
        table_q[learn_idx] <= '{valid: 1'b1, mac: learn_mac, port: learn_port, age: '0};
        if (!learn_match && !learn_free) repl_ptr_q <= repl_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_forwarding_engine.sv
// Store-header-then-forward switch engine: round-robin ingress arbitration,
// 12-byte header buffer, MAC lookup/learning, replay and cut-through payload.
// Optional feature macro: SWITCH_FORWARDING_ENGINE_AGING_EN (table aging).
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   port_receive_data        : per-port {last, byte[7:0]}
//   port_receive_data_valid  : per-port byte offered
//   port_receive_data_ready  : per-port byte accepted (only the granted port)
//   port_transmit_data       : shared egress {last, byte[7:0]}
//   port_transmit_data_valid : destination mask for the egress byte
//   frames_dropped           : saturating count of runt and filtered frames
//   debug_state              : current FSM state
//
// Handshake: an ingress byte transfers on a rising clock edge where both
// valid and ready are high; ready depends only on FSM state and grant, never
// on valid. The egress has no backpressure: a byte is delivered in every
// cycle its valid mask is non-zero.
module switch_forwarding_engine
  import switch_pkg::*;
#(
  parameter int NUMBER_OF_PORTS = 4,
  parameter int MAC_TABLE_DEPTH = 8,
  parameter int AGE_TICK_CYCLES = 1000000,
  parameter int AGE_LIMIT       = 255
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUMBER_OF_PORTS-1:0][8:0]     port_receive_data,
  input  logic [NUMBER_OF_PORTS-1:0]          port_receive_data_valid,
  output logic [NUMBER_OF_PORTS-1:0]          port_receive_data_ready,
  output logic [8:0]                          port_transmit_data,
  output logic [NUMBER_OF_PORTS-1:0]          port_transmit_data_valid,
  output logic [15:0]                         frames_dropped,
  output fsm_state_t                          debug_state
);

  localparam int         NP       = NUMBER_OF_PORTS;
  localparam int         PW       = $clog2(NP);
  localparam logic [3:0] LAST_HDR = 4'(HEADER_BYTES - 1);

  fsm_state_t        state_q, state_next;
  logic [PW-1:0]     grant_q, grant_next;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_next;
  logic [3:0]        cnt_q, cnt_next;
  logic [NP-1:0]     mask_q, mask_next;
  logic [8:0]        tx_data_q, tx_data_next;
  logic [NP-1:0]     tx_valid_q, tx_valid_next;
  logic [15:0]       drop_q;
  logic              drop_inc;
  logic              hdr_we;
  logic              learn_en;
  logic [NP-1:0]     ready;

  logic [7:0]        hdr_q [HEADER_BYTES];
  logic [47:0]       dst_mac;
  logic [47:0]       src_mac;
  logic              lookup_hit;
  logic [PORT_W-1:0] lookup_port;

  logic [NP-1:0]     grant_onehot;
  logic [8:0]        rx_byte;
  logic              accept;

  logic              arb_found;
  logic [PW-1:0]     arb_idx;
  int                arb_dist;
  int                arb_best;

  assign grant_onehot = NP'(1) << grant_q;
  assign rx_byte      = port_receive_data[grant_q];
  assign accept       = |(port_receive_data_valid & ready);

  assign dst_mac = {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
  assign src_mac = {hdr_q[6], hdr_q[7], hdr_q[8], hdr_q[9], hdr_q[10], hdr_q[11]};

  // Round-robin: pick the valid port with the smallest circular distance
  // from the pointer.
  always_comb begin
    arb_found = |port_receive_data_valid;
    arb_idx   = '0;
    arb_best  = NP;
    arb_dist  = 0;
    for (int i = 0; i < NP; i++) begin
      arb_dist = (i - int'(rr_ptr_q) + NP) % NP;
      if (port_receive_data_valid[i] && (arb_dist < arb_best)) begin
        arb_best = arb_dist;
        arb_idx  = PW'(i);
      end
    end
  end

  mac_learning_table #(
    .MAC_TABLE_DEPTH (MAC_TABLE_DEPTH),
    .AGE_TICK_CYCLES (AGE_TICK_CYCLES),
    .AGE_LIMIT       (AGE_LIMIT)
  ) u_table (
    .clock       (clock),
    .reset_n     (reset_n),
    .lookup_mac  (dst_mac),
    .lookup_hit  (lookup_hit),
    .lookup_port (lookup_port),
    .learn_en    (learn_en),
    .learn_mac   (src_mac),
    .learn_port  (PORT_W'(grant_q))
  );

  always_comb begin
    state_next    = state_q;
    grant_next    = grant_q;
    rr_ptr_next   = rr_ptr_q;
    cnt_next      = cnt_q;
    mask_next     = mask_q;
    tx_data_next  = '0;
    tx_valid_next = '0;
    drop_inc      = 1'b0;
    hdr_we        = 1'b0;
    learn_en      = 1'b0;
    ready         = '0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          grant_next  = arb_idx;
          rr_ptr_next = PW'((int'(arb_idx) + 1) % NP);
          cnt_next    = '0;
          state_next  = HEADER;
        end
      end
      HEADER: begin
        ready = grant_onehot;
        if (accept) begin
          hdr_we = 1'b1;
          if (rx_byte[8]) begin
            drop_inc   = 1'b1;
            state_next = IDLE;
          end else if (cnt_q == LAST_HDR) begin
            state_next = LOOKUP;
          end else begin
            cnt_next = cnt_q + 4'd1;
          end
        end
      end
      LOOKUP: begin
        learn_en   = 1'b1;
        cnt_next   = '0;
        state_next = FORWARD_HEADER;
        if ((dst_mac == BROADCAST_MAC) || !lookup_hit) begin
          mask_next = ~grant_onehot;
        end else if (lookup_port == PORT_W'(grant_q)) begin
          // Destination lives on the ingress port: consume the frame silently.
          mask_next = '0;
          drop_inc  = 1'b1;
        end else begin
          mask_next = NP'(1) << lookup_port;
        end
      end
      FORWARD_HEADER: begin
        tx_data_next  = {1'b0, hdr_q[cnt_q]};
        tx_valid_next = mask_q;
        if (cnt_q == LAST_HDR) state_next = FORWARD_PAYLOAD;
        else                   cnt_next   = cnt_q + 4'd1;
      end
      FORWARD_PAYLOAD: begin
        ready = grant_onehot;
        if (accept) begin
          tx_data_next  = rx_byte;
          tx_valid_next = mask_q;
          if (rx_byte[8]) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_next;
      grant_q    <= grant_next;
      rr_ptr_q   <= rr_ptr_next;
      cnt_q      <= cnt_next;
      mask_q     <= mask_next;
      tx_data_q  <= tx_data_next;
      tx_valid_q <= tx_valid_next;
      if (drop_inc && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  // Header buffer carries no reset: it is always rewritten before it is read.
  always_ff @(posedge clock) begin
    if (hdr_we) hdr_q[cnt_q] <= rx_byte[7:0];
  end

  assign port_receive_data_ready  = ready;
  assign port_transmit_data       = tx_data_q;
  assign port_transmit_data_valid = tx_valid_q;
  assign frames_dropped           = drop_q;
  assign debug_state              = state_q;

endmodule

// File: tb/tb_switch_forwarding_engine.sv
// Testbench for switch_forwarding_engine (4 ports, 2-entry table).
`timescale 1ns/1ps
module tb_switch_forwarding_engine;
  import switch_pkg::*;

  localparam int NP     = 4;
  localparam int DEPTH  = 2;
  localparam int W      = NP + 9;
  localparam int MAXLEN = 80;

  localparam logic [47:0] M1 = 48'h02_00_00_00_00_01;
  localparam logic [47:0] M2 = 48'h02_00_00_00_00_02;
  localparam logic [47:0] M3 = 48'h02_00_00_00_00_03;
  localparam logic [47:0] M4 = 48'h02_00_00_00_00_04;
  localparam logic [47:0] M5 = 48'h02_00_00_00_00_05;
  localparam logic [47:0] M6 = 48'h02_00_00_00_00_06;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [NP-1:0][8:0] rx_data;
  logic [NP-1:0]      rx_valid;
  logic [NP-1:0]      rx_ready;
  logic [8:0]         tx_data;
  logic [NP-1:0]      tx_valid;
  logic [15:0]        frames_dropped;
  fsm_state_t         debug_state;

  logic [8:0] drv_data  [NP];
  logic       drv_valid [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      rx_data[p]  = drv_data[p];
      rx_valid[p] = drv_valid[p];
    end
  end

  switch_forwarding_engine #(
    .NUMBER_OF_PORTS (NP),
    .MAC_TABLE_DEPTH (DEPTH),
    .AGE_TICK_CYCLES (10),
    .AGE_LIMIT       (3)
  ) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .port_receive_data        (rx_data),
    .port_receive_data_valid  (rx_valid),
    .port_receive_data_ready  (rx_ready),
    .port_transmit_data       (tx_data),
    .port_transmit_data_valid (tx_valid),
    .frames_dropped           (frames_dropped),
    .debug_state              (debug_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_q[$];
  int checks = 0;
  int errors = 0;
  int ready_viol = 0;

  always @(negedge clock) begin
    if (reset_n && (tx_valid != '0)) mon_q.push_back({tx_valid, tx_data});
    if (!$onehot0(rx_ready)) ready_viol++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_stream(input string name);
    int bad;
    bad = -1;
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s: got %0d egress beats expected %0d", name, mon_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++)
        if (bad < 0 && mon_q[i] !== exp_q[i]) bad = i;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s: beat %0d got %h expected %h", name, bad, mon_q[bad], exp_q[bad]);
      end
    end
    mon_q.delete();
    exp_q.delete();
  endtask

  // ---------------- frame driver ----------------
  logic [7:0] frame_mem [NP][MAXLEN];
  int         frame_len [NP];

  task automatic build_frame(input int p, input logic [47:0] dst, input logic [47:0] src,
                             input int len);
    logic [95:0] hdr;
    hdr = {dst, src};
    frame_len[p] = len;
    for (int i = 0; i < len; i++)
      frame_mem[p][i] = (i < 12) ? hdr[95 - 8*i -: 8] : 8'($urandom_range(0, 255));
  endtask

  task automatic expect_frame(input int p, input logic [NP-1:0] mask);
    logic last;
    if (mask != '0 && frame_len[p] > 12) begin
      for (int i = 0; i < frame_len[p]; i++) begin
        last = (i == frame_len[p] - 1);
        exp_q.push_back({mask, last, frame_mem[p][i]});
      end
    end
  endtask

  task automatic send_frame(input int p);
    int idx;
    int cyc;
    logic acc;
    logic last;
    idx = 0;
    cyc = 0;
    while (idx < frame_len[p] && cyc < 600) begin
      @(negedge clock);
      last = (idx == frame_len[p] - 1);
      drv_data[p]  = {last, frame_mem[p][idx]};
      drv_valid[p] = 1'b1;
      acc = rx_ready[p];
      @(posedge clock);
      if (acc) idx++;
      cyc++;
    end
    @(negedge clock);
    drv_valid[p] = 1'b0;
    drv_data[p]  = '0;
    checks++;
    if (idx < frame_len[p]) begin
      errors++;
      $display("FAIL send_port%0d: accepted %0d of %0d bytes", p, idx, frame_len[p]);
    end
  endtask

  task automatic drain();
    repeat (3) @(negedge clock);
  endtask

  // ---------------- reference model ----------------
  logic        m_valid [DEPTH];
  logic [47:0] m_mac   [DEPTH];
  int          m_port  [DEPTH];
  int          m_repl;
  int          m_drops;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_mac[i]   = '0;
      m_port[i]  = 0;
    end
    m_repl  = 0;
    m_drops = 0;
  endfunction

  // Returns the egress mask a frame should get (0 = nothing transmitted).
  function automatic logic [NP-1:0] model_frame(input int p, input logic [47:0] dst,
                                                input logic [47:0] src, input int len);
    logic [NP-1:0] mask;
    int hit_port;
    int slot;
    if (len <= 12) begin
      if (m_drops < 65535) m_drops++;
      return '0;
    end
    hit_port = -1;
    for (int i = 0; i < DEPTH; i++)
      if (hit_port < 0 && m_valid[i] && m_mac[i] == dst) hit_port = m_port[i];
    if (dst == BROADCAST_MAC || hit_port < 0) mask = ~(NP'(1) << p);
    else if (hit_port == p) begin
      mask = '0;
      if (m_drops < 65535) m_drops++;
    end else mask = NP'(1) << hit_port;
    slot = -1;
    for (int i = 0; i < DEPTH; i++) if (slot < 0 && m_valid[i] && m_mac[i] == src) slot = i;
    for (int i = 0; i < DEPTH; i++) if (slot < 0 && !m_valid[i]) slot = i;
    if (slot < 0) begin
      slot   = m_repl;
      m_repl = (m_repl + 1) % DEPTH;
    end
    m_valid[slot] = 1'b1;
    m_mac[slot]   = src;
    m_port[slot]  = p;
    return mask;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    for (int p = 0; p < NP; p++) drv_valid[p] = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    exp_q.delete();
    mon_q.delete();
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int            port;
    logic [47:0]   dst;
    logic [47:0]   src;
    int            len;
    logic [NP-1:0] exp_mask;
    int            exp_drops;
    string         name;
  } vec_t;

  vec_t vecs [8];

  function automatic void set_vec(input int i, input int p, input logic [47:0] dst,
                                  input logic [47:0] src, input int len,
                                  input logic [NP-1:0] mask, input int drops, input string name);
    vecs[i].port      = p;
    vecs[i].dst       = dst;
    vecs[i].src       = src;
    vecs[i].len       = len;
    vecs[i].exp_mask  = mask;
    vecs[i].exp_drops = drops;
    vecs[i].name      = name;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    set_vec(0, 1, BROADCAST_MAC, M1, 64, 4'b1101, 0, "bcast_learn");
    set_vec(1, 2, M1,            M2, 20, 4'b0010, 0, "unicast_hit");
    set_vec(2, 0, BROADCAST_MAC, M3,  5, 4'b0000, 1, "runt");
    set_vec(3, 3, M3,            M4, 16, 4'b0111, 1, "runt_not_learned");
    set_vec(4, 2, M1,            M2, 16, 4'b1011, 1, "evicted_entry0_floods");
    set_vec(5, 3, M4,            M2, 16, 4'b0000, 2, "filtered_same_port");
    set_vec(6, 0, M2,            M5, 16, 4'b1000, 2, "moved_station");
    set_vec(7, 1, M2,            M6, 16, 4'b1101, 2, "repl_ptr_wraps");

    for (int p = 0; p < NP; p++) begin
      drv_valid[p] = 1'b0;
      drv_data[p]  = '0;
    end
    model_reset();

    // Reset state, with a port offering data while reset is held.
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    drv_valid[2] = 1'b1;
    @(negedge clock);
    check_val("reset_ready", 64'(rx_ready), 64'd0);
    check_val("reset_tx_valid", 64'(tx_valid), 64'd0);
    check_val("reset_tx_data", 64'(tx_data), 64'd0);
    check_val("reset_dropped", 64'(frames_dropped), 64'd0);
    check_val("reset_state", 64'(debug_state), 64'(IDLE));
    drv_valid[2] = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);

`ifndef SWITCH_FORWARDING_ENGINE_AGING_EN
    for (int v = 0; v < 8; v++) begin
      build_frame(vecs[v].port, vecs[v].dst, vecs[v].src, vecs[v].len);
      expect_frame(vecs[v].port, vecs[v].exp_mask);
      send_frame(vecs[v].port);
      drain();
      compare_stream(vecs[v].name);
      check_val({vecs[v].name, "_dropped"}, 64'(frames_dropped), 64'(vecs[v].exp_drops));
    end
`endif

    // Ports 0 and 3 request in the same cycle right after reset.
    do_reset();
    build_frame(0, BROADCAST_MAC, M5, 14);
    build_frame(3, BROADCAST_MAC, M6, 14);
    expect_frame(0, 4'b1110);
    expect_frame(3, 4'b0111);
    fork
      send_frame(0);
      send_frame(3);
    join
    drain();
    compare_stream("arb_order_0_then_3");

    // Reset in the middle of a payload, then a clean frame.
    do_reset();
    @(negedge clock);
    drv_data[1]  = 9'h0AA;
    drv_valid[1] = 1'b1;
    repeat (30) @(negedge clock);
    check_val("midframe_state", 64'(debug_state), 64'(FORWARD_PAYLOAD));
    check_val("midframe_tx_valid", 64'(tx_valid), 64'(4'b1101));
    reset_n = 1'b0;
    #1;
    check_val("midreset_tx_valid", 64'(tx_valid), 64'd0);
    check_val("midreset_tx_data", 64'(tx_data), 64'd0);
    check_val("midreset_ready", 64'(rx_ready), 64'd0);
    check_val("midreset_state", 64'(debug_state), 64'(IDLE));
    drv_valid[1] = 1'b0;
    drv_data[1]  = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    mon_q.delete();
    exp_q.delete();
    model_reset();
    build_frame(2, BROADCAST_MAC, M1, 20);
    expect_frame(2, 4'b1011);
    send_frame(2);
    drain();
    compare_stream("after_midframe_reset");
    check_val("after_reset_dropped", 64'(frames_dropped), 64'd0);

`ifdef SWITCH_FORWARDING_ENGINE_AGING_EN
    // Learned entry left idle past the age limit must flood again.
    do_reset();
    build_frame(1, BROADCAST_MAC, M1, 13);
    expect_frame(1, 4'b1101);
    send_frame(1);
    drain();
    compare_stream("aging_learn");
    repeat (40) @(negedge clock);
    build_frame(2, M1, M2, 14);
    expect_frame(2, 4'b1011);
    send_frame(2);
    drain();
    compare_stream("aging_expired_floods");
`else
    // Randomized frames against the reference model.
    do_reset();
    for (int n = 0; n < 30; n++) begin
      int p;
      int len;
      int sel;
      logic [47:0] src;
      logic [47:0] dst;
      logic [NP-1:0] mask;
      p   = $urandom_range(0, NP - 1);
      src = 48'h02_00_00_00_01_00 | 48'($urandom_range(0, 3));
      sel = $urandom_range(0, 5);
      if (sel == 0)      dst = BROADCAST_MAC;
      else if (sel == 5) dst = 48'h0A_00_00_00_00_00 | 48'($urandom);
      else               dst = 48'h02_00_00_00_01_00 | 48'(sel - 1);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 12) : $urandom_range(13, 30);
      mask = model_frame(p, dst, src, len);
      build_frame(p, dst, src, len);
      expect_frame(p, mask);
      send_frame(p);
      drain();
      compare_stream($sformatf("random_%0d", n));
      check_val($sformatf("random_%0d_dropped", n), 64'(frames_dropped), 64'(m_drops));
    end
`endif

    check_val("ready_onehot_violations", 64'(ready_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
